// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_KILL,
    S_EXC
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        misaligned;
  } fetch_pkt_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for fetch packets; flush beats load beats unload.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  logic       unload,
  input  fetch_pkt_t din,
  output logic       valid,
  output fetch_pkt_t dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC register, imem req/ack FSM, and the registered output to ID
// backed by a one-entry skid buffer.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_misaligned
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] kill_addr;
  fetch_pkt_t  out_pkt;
  logic        out_valid;

  logic        skid_valid;
  fetch_pkt_t  skid_pkt;
  logic        skid_load;
  logic        skid_unload;

  logic        accept;
  logic        pending_no_ack;
  logic        out_xfer;
  logic        redir_mis;
  fetch_pkt_t  new_pkt;

  assign imem_req  = (state == S_KILL) || ((state == S_REQ) && !skid_valid);
  assign imem_addr = (state == S_KILL) ? kill_addr : pc;

  assign accept         = (state == S_REQ) && imem_req && imem_ack;
  assign pending_no_ack = imem_req && !imem_ack;
  // A misaligned-target report is sticky until the next redirect.
  assign out_xfer       = out_valid && !stall && !out_pkt.misaligned;
  assign redir_mis      = is_misaligned(redirect_pc);
  assign new_pkt        = '{instr: imem_rdata, pc: pc, misaligned: 1'b0};

  // Skid takes the new word when OUT stays occupied, or when OUT is being
  // refilled from the skid itself in the same cycle.
  always_comb begin
    skid_unload = out_xfer && skid_valid;
    skid_load   = 1'b0;
    if (accept) begin
      if (skid_valid) skid_load = out_xfer;
      else            skid_load = out_valid && !out_xfer;
    end
  end

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect),
    .load   (skid_load),
    .unload (skid_unload),
    .din    (new_pkt),
    .valid  (skid_valid),
    .dout   (skid_pkt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      kill_addr <= '0;
      out_pkt   <= '0;
      out_valid <= 1'b0;
    end else if (redirect) begin
      pc <= redirect_pc;
      if (redir_mis) begin
        out_valid <= 1'b1;
        out_pkt   <= '{instr: NOP_INSTR, pc: redirect_pc, misaligned: 1'b1};
      end else begin
        out_valid          <= 1'b0;
        out_pkt.instr      <= '0;
        out_pkt.misaligned <= 1'b0;
      end
      // An unacked request must still be completed (and discarded) before
      // the new target is fetched or the exception state is entered.
      if (pending_no_ack) begin
        state <= S_KILL;
        if (state != S_KILL) kill_addr <= pc;
      end else begin
        state <= redir_mis ? S_EXC : S_REQ;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ:  if (accept) pc <= pc + 32'd4;
        S_KILL: if (imem_ack) state <= is_misaligned(pc) ? S_EXC : S_REQ;
        S_EXC:  state <= S_EXC;
        default: state <= S_IDLE;
      endcase

      if (skid_valid && out_xfer) begin
        out_pkt <= skid_pkt;
      end else if (accept && (!out_valid || out_xfer)) begin
        out_pkt   <= new_pkt;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign if_instr      = out_pkt.instr;
  assign if_pc         = out_pkt.pc;
  assign if_valid      = out_valid;
  assign if_misaligned = out_pkt.misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_misaligned;

  logic        auto_ack;
  logic        man_ack;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a + 32'h0DEC_0000;
  endfunction

  always_comb begin
    imem_ack   = auto_ack ? imem_req : man_ack;
    imem_rdata = word_at(imem_addr);
  end

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .if_misaligned (if_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    auto_ack = 1'b1; man_ack = 1'b0;
    #1;
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_mis", if_misaligned, 0);

    // 1: streaming with a zero-wait memory
    tick; rst = 1'b0;
    tick;
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", if_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t1_valid", if_valid, 1);
      chk("t1_pc", if_pc, 32'(4 * i));
      chk("t1_instr", if_instr, word_at(32'(4 * i)));
      chk("t1_addr", imem_addr, 32'(4 * i + 4));
    end

    // 2: stall holds OUT, skid captures address 20, then drains in order
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t2_hold_pc", if_pc, 32'd16);
      chk("t2_hold_valid", if_valid, 1);
      chk("t2_req_off", imem_req, 0);
    end
    stall = 1'b0;
    tick;
    chk("t2_skid_pc", if_pc, 32'd20);
    chk("t2_skid_instr", if_instr, word_at(32'd20));
    chk("t2_req_back", imem_req, 1);
    chk("t2_addr", imem_addr, 32'd24);
    tick;
    chk("t2_next_pc", if_pc, 32'd24);
    tick;
    chk("t2_pc28", if_pc, 32'd28);
    chk("t2_addr32", imem_addr, 32'h20);

    // 3: redirect while the request for 0x20 is waiting on ack
    auto_ack = 1'b0; man_ack = 1'b0;
    tick;
    chk("t3_drain", if_valid, 0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick; redirect = 1'b0;
    chk("t3_kill_req", imem_req, 1);
    chk("t3_kill_addr", imem_addr, 32'h20);
    tick;
    chk("t3_kill_addr2", imem_addr, 32'h20);
    man_ack = 1'b1;
    tick; man_ack = 1'b0;
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_discard", if_valid, 0);
    auto_ack = 1'b1;
    tick;
    chk("t3_first_valid", if_valid, 1);
    chk("t3_first_pc", if_pc, 32'h100);

    // 4: redirect coincident with ack drops the acked word
    redirect = 1'b1; redirect_pc = 32'h300;
    tick; redirect = 1'b0;
    chk("t4_dropped", if_valid, 0);
    chk("t4_addr", imem_addr, 32'h300);
    tick;
    chk("t4_pc", if_pc, 32'h300);

    // 5: misaligned target
    redirect = 1'b1; redirect_pc = 32'h102;
    tick; redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t5_valid", if_valid, 1);
      chk("t5_mis", if_misaligned, 1);
      chk("t5_instr", if_instr, 32'h13);
      chk("t5_pc", if_pc, 32'h102);
      chk("t5_req", imem_req, 0);
      tick;
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick; redirect = 1'b0;
    chk("t5_clr_mis", if_misaligned, 0);
    chk("t5_addr", imem_addr, 32'h200);
    tick;
    chk("t5_pc200", if_pc, 32'h200);

    // 6: PC wrap, then asynchronous reset mid-request
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick; redirect = 1'b0;
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick;
    chk("t6_wrap", imem_addr, 32'h0);
    chk("t6_pc_top", if_pc, 32'hFFFF_FFFC);
    auto_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", if_valid, 0);
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_instr", if_instr, 0);
    chk("t6_rst_pc", if_pc, 0);
    tick; rst = 1'b0; auto_ack = 1'b1;
    tick;
    chk("t6_restart_addr", imem_addr, 32'h0);
    tick;
    chk("t6_restart_pc", if_pc, 32'h0);
    chk("t6_restart_valid", if_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
